// File: rtl/svm_pkg.sv
// Shared types and default widths for the SVM classifier lane.
package svm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_BIAS,
        ST_OUT
    } state_e;

    localparam int DEF_FEAT_W   = 8;
    localparam int DEF_WEIGHT_W = 12;
    localparam int DEF_ACC_W    = 32;
    localparam int PROD_W       = DEF_FEAT_W + DEF_WEIGHT_W + 1;

    // Unsigned feature gets one zero sign bit before the signed multiply.
    function automatic int prod_width(input int feat_w, input int weight_w);
        return feat_w + weight_w + 1;
    endfunction

endpackage

// File: rtl/svm_mac_lane.sv
// Single multiply-accumulate lane: unsigned feature times signed weight,
// summed into a wrapping signed accumulator.
module svm_mac_lane
    import svm_pkg::*;
#(
    parameter int FEAT_W   = DEF_FEAT_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int ACC_W    = DEF_ACC_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       enable,
    input  logic [FEAT_W-1:0]          a,
    input  logic signed [WEIGHT_W-1:0] b,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int MAC_W = prod_width(FEAT_W, WEIGHT_W);

    logic signed [MAC_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    always_comb begin
        prod  = MAC_W'($signed({1'b0, a})) * MAC_W'(b);
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/svm_dot_sequencer.sv
// One SVM dot-product evaluation: address generation, MAC control, bias add
// and a valid/ready result port.
module svm_dot_sequencer
    import svm_pkg::*;
#(
    parameter int FEAT_W   = DEF_FEAT_W,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int N_FEAT   = 64,
    parameter int ADDR_W   = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic [ADDR_W-1:0]          feat_addr,
    input  logic [FEAT_W-1:0]          feat_data,
    output logic [ADDR_W-1:0]          weight_addr,
    input  logic signed [WEIGHT_W-1:0] weight_data,
    input  logic signed [ACC_W-1:0]    bias,
    output logic signed [ACC_W-1:0]    score,
    output logic                       class_out,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_FEAT - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    vld_q, vld_d;
    logic signed [ACC_W-1:0] score_q, score_d;
    logic                    class_q, class_d;
    logic                    start_acc;
    logic signed [ACC_W-1:0] acc;

    svm_mac_lane #(
        .FEAT_W   (FEAT_W),
        .WEIGHT_W (WEIGHT_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_acc),
        .enable (vld_q),
        .a      (feat_data),
        .b      (weight_data),
        .acc    (acc)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        score_d   = score_q;
        class_d   = class_q;
        start_acc = 1'b0;
        // Memory data for an address issued in RUN arrives one cycle later.
        vld_d     = (state_q == ST_RUN);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    addr_d    = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_BIAS;
            end
            ST_BIAS: begin
                score_d = acc + bias;
                class_d = ~score_d[ACC_W-1];
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            score_q <= '0;
            class_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            score_q <= score_d;
            class_q <= class_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign feat_addr   = addr_q;
    assign weight_addr = addr_q;
    assign score       = score_q;
    assign class_out   = class_q;

endmodule

// File: tb/tb_svm_dot_sequencer.sv
// Self-checking bench for svm_dot_sequencer with a cycle-level behavioural model.
module tb_svm_dot_sequencer;

    localparam int N = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [31:0] bias = '0;
    logic               busy;
    logic [5:0]         feat_addr;
    logic [5:0]         weight_addr;
    logic [7:0]         feat_data;
    logic signed [11:0] weight_data;
    logic signed [31:0] score;
    logic               class_out;
    logic               out_valid;

    always #5 clock = ~clock;

    svm_dot_sequencer #(
        .FEAT_W   (8),
        .WEIGHT_W (12),
        .ACC_W    (32),
        .N_FEAT   (N),
        .ADDR_W   (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .feat_addr   (feat_addr),
        .feat_data   (feat_data),
        .weight_addr (weight_addr),
        .weight_data (weight_data),
        .bias        (bias),
        .score       (score),
        .class_out   (class_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    logic [7:0]         feat_mem   [64];
    logic signed [11:0] weight_mem [64];

    always @(posedge clock) begin
        feat_data   <= feat_mem[feat_addr];
        weight_data <= weight_mem[weight_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     nm, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Behavioural model: an evaluation is "on" from start acceptance until the
    // handshake; m_k counts edges since acceptance and stops at N+2 (result up).
    bit                 m_armed = 1'b0;
    bit                 m_on = 1'b0;
    int                 m_k = 0;
    int                 m_dot = 0;
    logic signed [31:0] m_score = '0;
    logic               m_class = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_on    = 1'b0;
            m_k     = 0;
            m_score = '0;
            m_class = 1'b0;
            m_armed = 1'b1;
        end else if (!m_on) begin
            if (start) begin
                m_on  = 1'b1;
                m_k   = 0;
                m_dot = 0;
                for (int i = 0; i < N; i++)
                    m_dot += int'(feat_mem[i]) * int'(weight_mem[i]);
            end
        end else if (m_k == N + 2) begin
            if (out_ready) m_on = 1'b0;
        end else begin
            m_k++;
            if (m_k == N + 2) begin
                m_score = m_dot + bias;
                m_class = (m_score >= 0);
            end
        end
    end

    always @(negedge clock) begin
        if (m_armed) begin
            chk("busy", 32'(busy), 32'(m_on));
            chk("out_valid", 32'(out_valid), 32'(m_on && (m_k == N + 2)));
            chk("score", score, m_score);
            chk("class_out", 32'(class_out), 32'(m_class));
            chk("addr_match", 32'(weight_addr), 32'(feat_addr));
            if (m_on && m_k < N) chk("feat_addr", 32'(feat_addr), 32'(m_k));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
    task automatic run_eval(input logic signed [31:0] b, input int hold,
                            output logic signed [31:0] sc, output logic cl, output int lat);
        bias      = b;
        start     = 1'b1;
        out_ready = (hold == 0);
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (!out_valid) chk("valid_timeout", 32'(0), 32'(1));
        sc = score;
        cl = class_out;
        for (int i = 0; i < hold; i++) begin
            start     = i[0];
            out_ready = 1'b0;
            @(negedge clock);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load_basic();
        feat_mem[0] = 8'd1;  weight_mem[0] = 12'sd1;
        feat_mem[1] = 8'd2;  weight_mem[1] = -12'sd1;
        feat_mem[2] = 8'd3;  weight_mem[2] = 12'sd2;
        feat_mem[3] = 8'd4;  weight_mem[3] = -12'sd2;
    endtask

    logic signed [31:0] sc;
    logic               cl;
    int                 lat;

    initial begin
        for (int i = 0; i < 64; i++) begin
            feat_mem[i]   = '0;
            weight_mem[i] = '0;
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;

        load_basic();
        run_eval(32'sd0, 0, sc, cl, lat);
        chk("basic_score", sc, -32'sd3);
        chk("basic_class", 32'(cl), 32'(0));
        chk("basic_latency", 32'(lat), 32'(6));

        run_eval(32'sd5, 0, sc, cl, lat);
        chk("bias5_score", sc, 32'sd2);
        chk("bias5_class", 32'(cl), 32'(1));

        run_eval(32'sd3, 0, sc, cl, lat);
        chk("zero_score", sc, 32'sd0);
        chk("zero_class", 32'(cl), 32'(1));

        for (int i = 0; i < N; i++) begin
            feat_mem[i]   = 8'd255;
            weight_mem[i] = -12'sd2048;
        end
        run_eval(32'sd0, 0, sc, cl, lat);
        chk("extreme_score", sc, -32'sd2088960);
        chk("extreme_class", 32'(cl), 32'(0));

        load_basic();
        run_eval(32'sd0, 10, sc, cl, lat);
        chk("backpressure_score", sc, -32'sd3);
        chk("backpressure_idle", 32'(busy), 32'(0));

        bias  = 32'sd0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_valid", 32'(out_valid), 32'(0));
        chk("reset_score", score, 32'sd0);
        reset = 1'b0;
        run_eval(32'sd0, 0, sc, cl, lat);
        chk("post_reset_score", sc, -32'sd3);

        run_eval(32'sd5, 0, sc, cl, lat);
        chk("b2b_first", sc, 32'sd2);
        run_eval(32'sd0, 0, sc, cl, lat);
        chk("b2b_second", sc, -32'sd3);

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                feat_mem[i]   = 8'($urandom_range(0, 255));
                weight_mem[i] = 12'($urandom_range(0, 4095));
            end
            run_eval($urandom, int'($urandom_range(0, 4)), sc, cl, lat);
            chk("rand_latency", 32'(lat), 32'(N + 2));
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
